mux_sweep_driver: RTL and testbench
===================================

Name: mux_sweep_driver

Overview:
Self-checking stimulus stage placed directly upstream of the 2:1 mux (inputs d1, d0, sel; output MuxOut, where sel=1 selects d1).
- Drives every {sel,d1,d0} combination into the mux, holding each for a programmable number of cycles.
- Samples the returned mux output and counts mismatches against the expected value.
- Reports pass/fail through a start/busy/done handshake.

Parameters:
HOLD_CYCLES, 4, cycles each vector is held on d1/d0/sel (must be >= 1)
SWEEPS, 1, number of full 8-vector passes per run (must be >= 1)
ERR_W, 8, width of error counter

Ports:
clk      input   1      system clock, rising edge
rst_n    input   1      asynchronous active-low reset
start    input   1      begin a run; sampled only in IDLE
abort    input   1      terminate a run early
mux_out  input   1      MuxOut returned from the mux under drive
d1       output  1      mux data input 1
d0       output  1      mux data input 0
sel      output  1      mux select
vec_idx  output  3      currently applied code {sel,d1,d0}
busy     output  1      high while in DRIVE
done     output  1      one-cycle pulse at normal completion
pass     output  1      run finished with zero mismatches; held until next start
err_cnt  output  ERR_W  saturating mismatch count

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset: the FSM goes to IDLE immediately. d1, d0, sel, vec_idx, busy, done, pass and err_cnt are all 0, as are the internal hold, sweep and step counters. All outputs are registered.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - start=1 and abort=0 -> next cycle enters DRIVE.
  - On entry: step=0, hold=0, sweep=0, err_cnt=0, pass=0.
  - Latency: the first vector appears on the cycle after start is sampled, with busy=1 on that same cycle.
  - abort=1 in IDLE overrides start; the FSM stays in IDLE.
- DRIVE:
  - {sel,d1,d0} = vec_idx = code(step). Each code is held for exactly HOLD_CYCLES cycles.
  - hold increments every cycle. On the cycle where hold==HOLD_CYCLES-1 (the sample cycle):
    - Compare mux_out with the expected value, which is d1 if sel=1, else d0.
    - On mismatch, err_cnt increments and saturates at 2^ERR_W-1.
    - hold returns to 0 and step advances. step wraps 7->0, and sweep increments on each wrap.
  - The sample cycle of step 7 when sweep==SWEEPS-1 -> DONE next cycle.
  - Total DRIVE length is 8*HOLD_CYCLES*SWEEPS cycles.
  - start is ignored while in DRIVE.
- abort=1 in DRIVE:
  - Next cycle -> IDLE with busy=0, d1/d0/sel/vec_idx=0, no done pulse and pass=0.
  - err_cnt keeps its value. A sample taken on the same cycle as abort is discarded.
- DONE (exactly one cycle):
  - done=1, busy=0, d1/d0/sel/vec_idx=0.
  - pass=(err_cnt==0), including the final sample, and is held until the next accepted start.
  - Then -> IDLE. A start in the DONE cycle is ignored.
- Reset asserted during DRIVE or DONE: outputs return to their reset values immediately, with no done pulse.
- mux_out is treated as a combinational return of the same-cycle registered outputs. HOLD_CYCLES=1 is legal: the sample is taken in the same cycle the vector is applied.

Optional Feature:
MUX_SWEEP_GRAY_EN
- Defined: code(step) follows Gray order 0,1,3,2,6,7,5,4, so exactly one mux input toggles per vector change.
- Undefined: binary order 0..7.
- Mismatch counting, done/pass timing and total length are identical in both builds.

Test Plan:
1. Defaults, ideal mux model, one start pulse:
   - busy=1 for 32 cycles; vec_idx 0..7, each held 4 cycles.
   - done pulses on cycle 33 after start; err_cnt=0, pass=1.
2. mux_out tied to 0, defaults (binary order):
   - Mismatches on codes 1, 3, 6, 7 -> err_cnt=4, pass=0 after done.
3. mux_out = inverse of the expected value, SWEEPS=40, ERR_W=5:
   - 320 mismatches; err_cnt saturates at 31; pass=0.
4. abort 10 cycles after start:
   - Next cycle: busy=0, outputs 0, no done pulse, pass=0, err_cnt retained.
   - A new start clears err_cnt and the run completes normally.
5. rst_n pulled low mid-DRIVE (between clock edges):
   - All outputs 0 immediately without waiting for an edge.
   - After release, IDLE ignores stale start until start is re-asserted.
6. MUX_SWEEP_GRAY_EN defined, HOLD_CYCLES=1:
   - vec_idx sequence 0,1,3,2,6,7,5,4; done on cycle 9; ideal mux -> pass=1.

Source files
------------

// File: rtl/mux_sweep_driver.sv
// Drives every {sel,d1,d0} code into a 2:1 mux, checks the returned output and reports pass/fail.
// Build option: define MUX_SWEEP_GRAY_EN to apply the codes in Gray order instead of binary order.
module mux_sweep_driver #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned SWEEPS      = 1,
   parameter int unsigned ERR_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             mux_out,
   output logic             d1,
   output logic             d0,
   output logic             sel,
   output logic [2:0]       vec_idx,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned SWEEP_W = (SWEEPS > 1) ? $clog2(SWEEPS) : 1;
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [SWEEP_W-1:0] SWEEP_LAST = SWEEP_W'(SWEEPS - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, DONE} stateT;

   stateT              state;
   logic [2:0]         vecReg;
   logic [2:0]         step;
   logic [HOLD_W-1:0]  hold;
   logic [SWEEP_W-1:0] sweep;
   logic               startArmed;

   logic               sampleNow;
   logic               expBit;
   logic               missNow;
   logic               lastSample;
   logic [2:0]         stepNext;
   logic [ERR_W-1:0]   errNext;

   function automatic logic [2:0] codeOf(input logic [2:0] s);
`ifdef MUX_SWEEP_GRAY_EN
      return s ^ (s >> 1);
`else
      return s;
`endif
   endfunction

   assign sel     = vecReg[2];
   assign d1      = vecReg[1];
   assign d0      = vecReg[0];
   assign vec_idx = vecReg;

   // Sample-cycle decode; mux_out answers the vector currently on the registered outputs
   always_comb begin
      sampleNow  = (hold == HOLD_LAST);
      expBit     = vecReg[2] ? vecReg[1] : vecReg[0];
      missNow    = sampleNow && (mux_out != expBit);
      lastSample = sampleNow && (step == 3'd7) && (sweep == SWEEP_LAST);
      stepNext   = step + 3'd1;
      errNext    = err_cnt;
      if (missNow && (err_cnt != {ERR_W{1'b1}})) begin
         errNext = err_cnt + ERR_W'(1);
      end
   end

   // A start still held from before reset is not taken until start has been seen low once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         vecReg     <= 3'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_cnt    <= '0;
         hold       <= '0;
         step       <= 3'd0;
         sweep      <= '0;
         startArmed <= 1'b0;
      end else begin
         done       <= 1'b0;
         startArmed <= startArmed | ~start;
         case (state)
            IDLE: begin
               if (start && !abort && startArmed) begin
                  state   <= DRIVE;
                  busy    <= 1'b1;
                  vecReg  <= codeOf(3'd0);
                  hold    <= '0;
                  step    <= 3'd0;
                  sweep   <= '0;
                  err_cnt <= '0;
                  pass    <= 1'b0;
               end
            end
            DRIVE: begin
               if (abort) begin
                  state  <= IDLE;
                  busy   <= 1'b0;
                  vecReg <= 3'd0;
                  pass   <= 1'b0;
                  hold   <= '0;
                  step   <= 3'd0;
                  sweep  <= '0;
               end else if (sampleNow) begin
                  err_cnt <= errNext;
                  hold    <= '0;
                  step    <= stepNext;
                  vecReg  <= codeOf(stepNext);
                  if (step == 3'd7) begin
                     sweep <= sweep + SWEEP_W'(1);
                  end
                  if (lastSample) begin
                     state  <= DONE;
                     busy   <= 1'b0;
                     vecReg <= 3'd0;
                     done   <= 1'b1;
                     pass   <= (errNext == '0);
                     sweep  <= '0;
                  end
               end else begin
                  hold <= hold + HOLD_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_sweep_driver.sv
// Scoreboard bench for mux_sweep_driver: three parameterisations, each driving its own mux model.
module tb_mux_sweep_driver;

   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       startS [NI];
   logic       abortS [NI];
   logic       muxS   [NI];
   logic       d1S    [NI];
   logic       d0S    [NI];
   logic       selS   [NI];
   logic [2:0] vecS   [NI];
   logic       busyS  [NI];
   logic       doneS  [NI];
   logic       passS  [NI];
   logic [7:0] errA;
   logic [7:0] errB;
   logic [4:0] errC;
   int         modeS  [NI];

   int vectors     = 0;
   int miscompares = 0;

   int holdOf   [NI] = '{4, 1, 4};
   int sweepsOf [NI] = '{1, 1, 40};
   int errMaxOf [NI] = '{255, 255, 31};
   int grayTab  [8]  = '{0, 1, 3, 2, 6, 7, 5, 4};

   typedef struct {
      logic [2:0] vec;
      int         err;
   } expT;

   expT expQ[$];

   always #5 clk = ~clk;

   // mode 0: ideal mux, 1: output stuck at 0, 2: inverted output
   function automatic logic muxModel(input int mode, input logic s, input logic a, input logic b);
      logic e;
      e = s ? a : b;
      case (mode)
         0:       return e;
         1:       return 1'b0;
         default: return ~e;
      endcase
   endfunction

   assign muxS[0] = muxModel(modeS[0], selS[0], d1S[0], d0S[0]);
   assign muxS[1] = muxModel(modeS[1], selS[1], d1S[1], d0S[1]);
   assign muxS[2] = muxModel(modeS[2], selS[2], d1S[2], d0S[2]);

   mux_sweep_driver dutA (
      .clk(clk), .rst_n(rst_n), .start(startS[0]), .abort(abortS[0]), .mux_out(muxS[0]),
      .d1(d1S[0]), .d0(d0S[0]), .sel(selS[0]), .vec_idx(vecS[0]), .busy(busyS[0]),
      .done(doneS[0]), .pass(passS[0]), .err_cnt(errA)
   );

   mux_sweep_driver #(.HOLD_CYCLES(1)) dutB (
      .clk(clk), .rst_n(rst_n), .start(startS[1]), .abort(abortS[1]), .mux_out(muxS[1]),
      .d1(d1S[1]), .d0(d0S[1]), .sel(selS[1]), .vec_idx(vecS[1]), .busy(busyS[1]),
      .done(doneS[1]), .pass(passS[1]), .err_cnt(errB)
   );

   mux_sweep_driver #(.SWEEPS(40), .ERR_W(5)) dutC (
      .clk(clk), .rst_n(rst_n), .start(startS[2]), .abort(abortS[2]), .mux_out(muxS[2]),
      .d1(d1S[2]), .d0(d0S[2]), .sel(selS[2]), .vec_idx(vecS[2]), .busy(busyS[2]),
      .done(doneS[2]), .pass(passS[2]), .err_cnt(errC)
   );

   function automatic int errOf(input int w);
      case (w)
         0:       return int'(errA);
         1:       return int'(errB);
         default: return int'(errC);
      endcase
   endfunction

   function automatic logic [2:0] benchCode(input int s);
`ifdef MUX_SWEEP_GRAY_EN
      return 3'(grayTab[s]);
`else
      return 3'(s);
`endif
   endfunction

   // One run on instance w; abortAt>0 aborts in that run cycle, midStart>0 pulses start mid-run
   task automatic runSweep(input int w, input int mode, input int abortAt, input int midStart, input string name);
      int         hold;
      int         total;
      int         n;
      int         errModel;
      expT        e;
      logic [2:0] v;
      logic       ebit;
      hold     = holdOf[w];
      total    = 8 * hold * sweepsOf[w];
      n        = (abortAt > 0) ? abortAt : total;
      errModel = 0;
      modeS[w] = mode;
      expQ.delete();
      for (int k = 1; k <= n; k++) begin
         v     = benchCode(((k - 1) / hold) % 8);
         e.vec = v;
         e.err = errModel;
         expQ.push_back(e);
         if (((k - 1) % hold == hold - 1) && (k != abortAt)) begin
            ebit = v[2] ? v[1] : v[0];
            if ((mode == 2 || (mode == 1 && ebit)) && errModel < errMaxOf[w]) errModel++;
         end
      end
      @(posedge clk); #1 startS[w] = 1'b1;
      @(posedge clk); #1 startS[w] = 1'b0;
      for (int k = 1; k <= n; k++) begin
         e = expQ.pop_front();
         vectors++;
         if (busyS[w] !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy cyc%0d: got %b expected 1", name, k, busyS[w]);
         end
         vectors++;
         if (vecS[w] !== e.vec || {selS[w], d1S[w], d0S[w]} !== e.vec) begin
            miscompares++;
            $display("FAIL %s vector cyc%0d: got idx %0d pins %b%b%b expected %0d",
                     name, k, vecS[w], selS[w], d1S[w], d0S[w], e.vec);
         end
         vectors++;
         if (errOf(w) !== e.err) begin
            miscompares++;
            $display("FAIL %s err_cnt cyc%0d: got %0d expected %0d", name, k, errOf(w), e.err);
         end
         startS[w] = (k == midStart);
         abortS[w] = (k == abortAt);
         @(posedge clk); #1;
      end
      startS[w] = 1'b0;
      abortS[w] = 1'b0;
      vectors++;
      if (abortAt > 0) begin
         if (busyS[w] !== 1'b0 || doneS[w] !== 1'b0 || passS[w] !== 1'b0 || vecS[w] !== 3'd0 ||
             {selS[w], d1S[w], d0S[w]} !== 3'd0 || errOf(w) !== errModel) begin
            miscompares++;
            $display("FAIL %s after abort: got busy %b done %b pass %b idx %0d err %0d expected 0 0 0 0 %0d",
                     name, busyS[w], doneS[w], passS[w], vecS[w], errOf(w), errModel);
         end
         @(posedge clk); #1;
         vectors++;
         if (doneS[w] !== 1'b0 || busyS[w] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s late done after abort: got done %b busy %b expected 0 0", name, doneS[w], busyS[w]);
         end
      end else begin
         if (doneS[w] !== 1'b1 || busyS[w] !== 1'b0 || vecS[w] !== 3'd0 ||
             passS[w] !== (errModel == 0) || errOf(w) !== errModel) begin
            miscompares++;
            $display("FAIL %s done cycle: got done %b busy %b idx %0d pass %b err %0d expected 1 0 0 %b %0d",
                     name, doneS[w], busyS[w], vecS[w], passS[w], errOf(w), errModel == 0, errModel);
         end
         startS[w] = 1'b1;
         @(posedge clk); #1 startS[w] = 1'b0;
         vectors++;
         if (doneS[w] !== 1'b0 || busyS[w] !== 1'b0 || passS[w] !== (errModel == 0)) begin
            miscompares++;
            $display("FAIL %s after done: got done %b busy %b pass %b expected 0 0 %b",
                     name, doneS[w], busyS[w], passS[w], errModel == 0);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) begin
         startS[i] = 1'b0;
         abortS[i] = 1'b0;
         modeS[i]  = 0;
      end
      #2;
      for (int i = 0; i < NI; i++) begin
         vectors++;
         if (busyS[i] !== 1'b0 || doneS[i] !== 1'b0 || passS[i] !== 1'b0 || vecS[i] !== 3'd0 ||
             {selS[i], d1S[i], d0S[i]} !== 3'd0 || errOf(i) !== 0) begin
            miscompares++;
            $display("FAIL reset inst%0d: got busy %b done %b pass %b idx %0d err %0d expected all 0",
                     i, busyS[i], doneS[i], passS[i], vecS[i], errOf(i));
         end
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_idle_abort();
      startS[0] = 1'b1;
      abortS[0] = 1'b1;
      @(posedge clk); #1;
      startS[0] = 1'b0;
      abortS[0] = 1'b0;
      vectors++;
      if (busyS[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_abort: got busy %b expected 0", busyS[0]);
      end
   endtask

   task automatic test_reset_mid_drive();
      modeS[0] = 1;
      @(posedge clk); #1 startS[0] = 1'b1;
      @(posedge clk); #1 startS[0] = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      vectors++;
      if (busyS[0] !== 1'b1 || errA !== 8'd1) begin
         miscompares++;
         $display("FAIL reset_mid pre: got busy %b err %0d expected 1 1", busyS[0], errA);
      end
      #2 startS[0] = 1'b1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (busyS[0] !== 1'b0 || doneS[0] !== 1'b0 || passS[0] !== 1'b0 || vecS[0] !== 3'd0 ||
          {selS[0], d1S[0], d0S[0]} !== 3'd0 || errA !== 8'd0) begin
         miscompares++;
         $display("FAIL reset_mid async: got busy %b done %b pass %b idx %0d err %0d expected all 0",
                  busyS[0], doneS[0], passS[0], vecS[0], errA);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (busyS[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid stale start: got busy %b expected 0", busyS[0]);
      end
      startS[0] = 1'b0;
      @(posedge clk); #1 startS[0] = 1'b1;
      @(posedge clk); #1 startS[0] = 1'b0;
      vectors++;
      if (busyS[0] !== 1'b1 || errA !== 8'd0) begin
         miscompares++;
         $display("FAIL reset_mid restart: got busy %b err %0d expected 1 0", busyS[0], errA);
      end
      abortS[0] = 1'b1;
      @(posedge clk); #1 abortS[0] = 1'b0;
      vectors++;
      if (busyS[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid abort: got busy %b expected 0", busyS[0]);
      end
   endtask

   task automatic test_ideal();           runSweep(0, 0, 0, 5, "ideal");            endtask
   task automatic test_stuck_low();       runSweep(0, 1, 0, 0, "stuck_low");        endtask
   task automatic test_saturate();        runSweep(2, 2, 0, 0, "saturate");         endtask
   task automatic test_abort();
      runSweep(0, 1, 10, 0, "abort10");
      runSweep(0, 0, 0, 0, "after_abort");
      runSweep(0, 1, 8, 0, "abort_on_sample");
   endtask
   task automatic test_order_hold1();
      runSweep(1, 0, 0, 0, "order_hold1");
      runSweep(1, 2, 0, 0, "inverted_hold1");
   endtask
   task automatic test_back_to_back();
      runSweep(0, 1, 0, 0, "b2b_first");
      runSweep(0, 0, 0, 0, "b2b_second");
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_stuck_low();
      test_saturate();
      test_abort();
      test_idle_abort();
      test_reset_mid_drive();
      test_order_hold1();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
